dm_responder: RTL and testbench

DM_RESPONDER -- requirements
Module: dm_responder

---
 rtl/dm_responder.sv | 95 +++++++++
 tb/tb_dm_responder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// dm_responder: wait-state data memory responder with byte/half/word access and error reporting
module dm_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [1:0]  DMWr,
    input  logic [3:0]  DMRd,
    input  logic [31:0] DMaddr,
    input  logic [31:0] DMdata,
    output logic        ack,
    output logic [31:0] DMout,
    output logic        err
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [1:0]  r_wr;
    logic [3:0]  r_rd;
    logic [31:0] r_addr, r_data;
    logic [31:0] r_mem [DEPTH_WORDS];
    logic        w_idle, w_go, w_access, w_err;
    logic [1:0]  w_wr, w_lane;
    logic [3:0]  w_rd;
    logic [31:0] w_addr, w_data, w_word, w_load;
    logic [AW-1:0] w_idx;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    // without wait states the response is decided from the live inputs in IDLE
    always_comb begin
        w_idle   = r_state == IDLE;
        w_go     = w_idle ? (req && WAIT_CYCLES == 0) : (r_state == WAIT && r_cnt == 4'd0);
        w_wr     = w_idle ? DMWr : r_wr;
        w_rd     = w_idle ? DMRd : r_rd;
        w_addr   = w_idle ? DMaddr : r_addr;
        w_data   = w_idle ? DMdata : r_data;
        w_lane   = w_addr[1:0];
        w_idx    = w_addr[AW+1:2];
        w_access = w_wr != 2'd0 || w_rd != 4'd0;
        w_err    = (w_wr != 2'd0 && w_rd != 4'd0) || w_rd > 4'd5
                 || ((w_wr == 2'd1 || w_rd == 4'd1) && w_lane != 2'd0)
                 || ((w_wr == 2'd2 || w_rd == 4'd2 || w_rd == 4'd3) && w_lane[0])
                 || (w_access && w_addr[31:2] >= 30'(DEPTH_WORDS));
        w_word   = r_mem[w_idx];
        w_byte   = 8'(w_word >> {w_lane, 3'b000});
        w_half   = 16'(w_word >> {w_lane[1], 4'b0000});
        w_load   = w_rd == 4'd1 ? w_word
                 : w_rd == 4'd2 ? {{16{w_half[15]}}, w_half}
                 : w_rd == 4'd3 ? {16'd0, w_half}
                 : w_rd == 4'd4 ? {{24{w_byte[7]}}, w_byte}
                 : w_rd == 4'd5 ? {24'd0, w_byte} : 32'd0;
    end
    always_ff @(posedge clk) begin
        if (rst && w_go && !w_err) begin
            if (w_wr == 2'd1) r_mem[w_idx] <= w_data;
            else if (w_wr == 2'd2) r_mem[w_idx][{w_lane[1], 4'b0000} +: 16] <= w_data[15:0];
            else if (w_wr == 2'd3) r_mem[w_idx][{w_lane, 3'b000} +: 8] <= w_data[7:0];
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_wr    <= 2'd0;
            r_rd    <= 4'd0;
            r_addr  <= 32'd0;
            r_data  <= 32'd0;
            ack     <= 1'b0;
            err     <= 1'b0;
            DMout   <= 32'd0;
        end else begin
            ack   <= w_go;
            err   <= w_go && w_err;
            DMout <= (w_go && !w_err) ? w_load : 32'd0;
            case (r_state)
                IDLE: if (req) begin
                    r_wr    <= DMWr;
                    r_rd    <= DMRd;
                    r_addr  <= DMaddr;
                    r_data  <= DMdata;
                    r_state <= WAIT_CYCLES == 0 ? RESP : WAIT;
                    r_cnt   <= WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);
                end
                WAIT: begin
                    r_state <= r_cnt == 4'd0 ? RESP : WAIT;
                    r_cnt   <= r_cnt == 4'd0 ? 4'd0 : r_cnt - 4'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: randomized and directed checks of dm_responder against a byte-addressed model
module tb_dm_responder;
    localparam int W = 2;
    localparam int DEPTH = 1024;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0, req1 = 1'b0;
    logic [1:0]  DMWr = 2'd0;
    logic [3:0]  DMRd = 4'd0;
    logic [31:0] DMaddr = 32'd0, DMdata = 32'd0;
    logic        ack, err, ack1, err1;
    logic [31:0] DMout, dout1;
    int          cyc = 0;
    int          vectors = 0, fails = 0;
    logic        last_err;
    logic [31:0] last_dout;
    typedef struct {int c; logic e; logic [31:0] o;} exp_t;
    exp_t        q[$];
    logic [7:0]  mem_b[int];

    dm_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .req(req), .DMWr(DMWr), .DMRd(DMRd), .DMaddr(DMaddr),
        .DMdata(DMdata), .ack(ack), .DMout(DMout), .err(err));
    dm_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req1), .DMWr(DMWr), .DMRd(DMRd), .DMaddr(DMaddr),
        .DMdata(DMdata), .ack(ack1), .DMout(dout1), .err(err1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // reference: memory as individual bytes, access size chosen from the opcode
    task automatic model(input logic [1:0] wr, input logic [3:0] rd, input logic [31:0] a,
                         input logic [31:0] d, output logic e, output logic [31:0] o);
        int n;
        logic [31:0] v;
        n = wr == 1 ? 4 : wr == 2 ? 2 : wr == 3 ? 1 : rd == 1 ? 4 : (rd == 2 || rd == 3) ? 2 : (rd == 4 || rd == 5) ? 1 : 0;
        e = (wr != 0 && rd != 0) || rd > 5 || (n != 0 && (a % n) != 0) || (n != 0 && (a >> 2) >= DEPTH);
        o = 0;
        v = 0;
        if (!e && wr != 0) begin
            for (int i = 0; i < n; i++) mem_b[int'(a) + i] = d[8*i +: 8];
        end else if (!e && rd != 0) begin
            for (int i = 0; i < n; i++) v[8*i +: 8] = mem_b.exists(int'(a) + i) ? mem_b[int'(a) + i] : 8'h00;
            if (rd == 2) o = {{16{v[15]}}, v[15:0]};
            else if (rd == 3) o = {16'd0, v[15:0]};
            else if (rd == 4) o = {{24{v[7]}}, v[7:0]};
            else if (rd == 5) o = {24'd0, v[7:0]};
            else o = v;
        end
    endtask

    task automatic txn(input logic [1:0] wr, input logic [3:0] rd, input logic [31:0] a, input logic [31:0] d);
        logic e;
        logic [31:0] o;
        model(wr, rd, a, d, e, o);
        q.push_back('{cyc + 1 + W, e, o});
        DMWr = wr; DMRd = rd; DMaddr = a; DMdata = d; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        DMWr = 2'($urandom); DMRd = 4'($urandom); DMaddr = $urandom; DMdata = $urandom;
        repeat (W + 1) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].c < cyc) begin
            chk("ack_missing", 32'(ack), 32'd1);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].c == cyc) begin
            chk("ack", 32'(ack), 32'd1);
            chk("err", 32'(err), 32'(q[0].e));
            chk("dout", DMout, q[0].o);
            last_err = err;
            last_dout = DMout;
            void'(q.pop_front());
        end else begin
            chk("idle_ack", 32'(ack), 32'd0);
            chk("idle_err", 32'(err), 32'd0);
            chk("idle_dout", DMout, 32'd0);
        end
    end

    initial begin
        logic [1:0] wr;
        logic [3:0] rd;
        logic [31:0] a;
        int sel;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) txn(2'd1, 4'd0, 32'(i * 4), $urandom);
        txn(2'd1, 4'd0, 32'h10, 32'hDEADBEEF);
        chk("sw10_err", 32'(last_err), 32'd0);
        txn(2'd0, 4'd1, 32'h10, 32'h0);
        chk("lw10", last_dout, 32'hDEADBEEF);
        txn(2'd3, 4'd0, 32'h11, 32'h80);
        txn(2'd0, 4'd4, 32'h11, 32'h0);
        chk("lb11", last_dout, 32'hFFFFFF80);
        txn(2'd0, 4'd5, 32'h11, 32'h0);
        chk("lbu11", last_dout, 32'h00000080);
        txn(2'd0, 4'd1, 32'h10, 32'h0);
        chk("lw10_merged", last_dout, 32'hDEAD80EF);
        txn(2'd0, 4'd2, 32'h12, 32'h0);
        chk("lh12", last_dout, 32'hFFFFDEAD);
        txn(2'd0, 4'd3, 32'h12, 32'h0);
        chk("lhu12", last_dout, 32'h0000DEAD);
        txn(2'd0, 4'd2, 32'h13, 32'h0);
        chk("lh13_err", 32'(last_err), 32'd1);
        chk("lh13_dout", last_dout, 32'd0);
        txn(2'd1, 4'd0, 32'h1000, 32'hCAFEF00D);
        chk("sw_oor_err", 32'(last_err), 32'd1);
        txn(2'd0, 4'd1, 32'h0, 32'h0);
        chk("lw0_kept", last_dout, {mem_b[3], mem_b[2], mem_b[1], mem_b[0]});
        txn(2'd1, 4'd1, 32'h4, 32'h1);
        chk("wr_rd_err", 32'(last_err), 32'd1);
        txn(2'd0, 4'd0, 32'h4, 32'h1);
        chk("none_err", 32'(last_err), 32'd0);
        txn(2'd0, 4'd7, 32'h4, 32'h0);
        chk("illegal_rd_err", 32'(last_err), 32'd1);
        // reset during WAIT: the store to 0x20 must be dropped and no ack seen
        DMWr = 2'd1; DMRd = 4'd0; DMaddr = 32'h20; DMdata = 32'h12345678; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        txn(2'd0, 4'd1, 32'h20, 32'h0);
        chk("lw20_prior", last_dout, {mem_b[35], mem_b[34], mem_b[33], mem_b[32]});
        DMWr = 2'd0; DMRd = 4'd0; req1 = 1'b1;
        @(negedge clk); chk("w0_ack_a", 32'(ack1), 32'd1);
        @(negedge clk); chk("w0_ack_b", 32'(ack1), 32'd0);
        @(negedge clk); chk("w0_ack_c", 32'(ack1), 32'd1);
        chk("w0_err_c", 32'(err1), 32'd0);
        chk("w0_dout_c", dout1, 32'd0);
        @(negedge clk); chk("w0_ack_d", 32'(ack1), 32'd0);
        req1 = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 150; k++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 4) begin wr = 2'd0; rd = 4'($urandom_range(1, 5)); end
            else if (sel < 7) begin wr = 2'($urandom_range(1, 3)); rd = 4'd0; end
            else begin wr = 2'($urandom); rd = 4'($urandom_range(0, 7)); end
            sel = int'($urandom_range(0, 9));
            a = sel < 8 ? 32'($urandom_range(0, 63)) : sel < 9 ? 32'h1000 + 32'($urandom_range(0, 255)) : $urandom;
            txn(wr, rd, a, $urandom);
        end
        repeat (2) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
